guard_recovery_ctrl: RTL and testbench



---
 rtl/slv_pkg.sv | 27 ++
 rtl/recovery_timer.sv | 30 +++
 rtl/guard_recovery_ctrl.sv | 144 ++++++++++++++
 tb/tb_guard_recovery_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/slv_pkg.sv
// Shared types for the guarded-slave recovery controller.
//   recovery_state_e : sequencer states
//   recovery_cause_t : latched recovery cause {drain_to, wr, rd}
//   max3             : helper used to size the shared timer
package slv_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StDrain   = 3'd1,
        StReset   = 3'd2,
        StRecover = 3'd3,
        StClear   = 3'd4
    } recovery_state_e;

    typedef struct packed {
        logic drain_to;
        logic wr;
        logic rd;
    } recovery_cause_t;

    function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/recovery_timer.sv
// Shared up-counter for the recovery sequencer.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clear_i      : force the count to zero (has priority over enable_i)
//   enable_i     : increment the count
//   term_i       : terminal value to compare against
//   done_o       : count equals term_i
module recovery_timer #(
    parameter int unsigned Width = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [Width-1:0] term_i,
    output logic             done_o
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign done_o = (count_q == term_i);

endmodule

// File: rtl/guard_recovery_ctrl.sv
// Recovery sequencer for a guarded AXI slave: isolate, drain (bounded),
// reset the slave, wait a recovery window, then clear the guards.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   enable_i               : allow a new sequence to start
//   rd/wr_reset_req_i      : level reset requests from the guards
//   rd/wr_outstanding_i    : outstanding transaction counts
//   irq_ack_i              : clear irq_o
//   isolate_o, slv_rst_o   : slave isolation and reset
//   reset_clear_o          : guard reset-state clear
//   guard_en_o, busy_o     : guard enable (low while recovering), sequencer busy
//   irq_o, cause_o         : sticky interrupt, latched cause {drain_to, wr, rd}
//   reset_cnt_o            : saturating count of RESET entries
module guard_recovery_ctrl
    import slv_pkg::*;
#(
    parameter int unsigned DrainCycles   = 256,
    parameter int unsigned RstCycles     = 16,
    parameter int unsigned RecoverCycles = 8,
    parameter int unsigned OutCntWidth   = 6,
    parameter int unsigned RstCntWidth   = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic                   rd_reset_req_i,
    input  logic                   wr_reset_req_i,
    input  logic [OutCntWidth-1:0] rd_outstanding_i,
    input  logic [OutCntWidth-1:0] wr_outstanding_i,
    input  logic                   irq_ack_i,
    output logic                   isolate_o,
    output logic                   slv_rst_o,
    output logic                   reset_clear_o,
    output logic                   guard_en_o,
    output logic                   busy_o,
    output logic                   irq_o,
    output logic [2:0]             cause_o,
    output logic [RstCntWidth-1:0] reset_cnt_o
);

    localparam int unsigned TimerMax   = max3(DrainCycles, RstCycles, RecoverCycles);
    localparam int unsigned TimerWidth = $clog2(TimerMax + 1);

    if (DrainCycles < 1 || RstCycles < 1 || RecoverCycles < 1) begin : g_bad_params
        $error("guard_recovery_ctrl: cycle parameters must be >= 1");
    end

    recovery_state_e       state_q, state_d;
    recovery_cause_t       cause_q;
    logic                  isolate_q, slv_rst_q, reset_clear_q, guard_en_q, busy_q, irq_q;
    logic [RstCntWidth-1:0] reset_cnt_q;

    logic                  start;
    logic                  outs_zero;
    logic                  timer_clear;
    logic                  timer_done;
    logic [TimerWidth-1:0] timer_term;

    assign start     = enable_i && (rd_reset_req_i || wr_reset_req_i);
    assign outs_zero = (rd_outstanding_i == '0) && (wr_outstanding_i == '0);

    // Timer restarts on every state change, so each state counts from zero.
    assign timer_clear = (state_d != state_q) || (state_q == StIdle) || (state_q == StClear);

    always_comb begin
        timer_term = '0;
        unique case (state_q)
            StDrain:   timer_term = TimerWidth'(DrainCycles - 1);
            StReset:   timer_term = TimerWidth'(RstCycles - 1);
            StRecover: timer_term = TimerWidth'(RecoverCycles - 1);
            default:   timer_term = '0;
        endcase
    end

    recovery_timer #(
        .Width (TimerWidth)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (timer_clear),
        .enable_i (!timer_clear),
        .term_i   (timer_term),
        .done_o   (timer_done)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StDrain;
            StDrain:   if (outs_zero || timer_done) state_d = StReset;
            StReset:   if (timer_done) state_d = StRecover;
            StRecover: if (timer_done) state_d = StClear;
            StClear:   if (!rd_reset_req_i && !wr_reset_req_i) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Outputs are registered decodes of the next state so they line up with state_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            isolate_q     <= 1'b0;
            slv_rst_q     <= 1'b0;
            reset_clear_q <= 1'b0;
            guard_en_q    <= 1'b1;
            busy_q        <= 1'b0;
            irq_q         <= 1'b0;
            cause_q       <= '0;
            reset_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            isolate_q     <= (state_d == StDrain) || (state_d == StReset) ||
                             (state_d == StRecover);
            slv_rst_q     <= (state_d == StReset);
            reset_clear_q <= (state_d == StClear);
            guard_en_q    <= (state_d == StIdle);
            busy_q        <= (state_d != StIdle);

            if (state_q == StIdle && state_d == StDrain) begin
                irq_q            <= 1'b1;
                cause_q.drain_to <= 1'b0;
                cause_q.wr       <= wr_reset_req_i;
                cause_q.rd       <= rd_reset_req_i;
            end else if (irq_ack_i) begin
                irq_q <= 1'b0;
            end

            if (state_q == StDrain && state_d == StReset) begin
                // Leaving DRAIN with traffic still pending means the timeout fired.
                if (!outs_zero) cause_q.drain_to <= 1'b1;
                if (reset_cnt_q != '1) reset_cnt_q <= reset_cnt_q + 1'b1;
            end
        end
    end

    assign isolate_o     = isolate_q;
    assign slv_rst_o     = slv_rst_q;
    assign reset_clear_o = reset_clear_q;
    assign guard_en_o    = guard_en_q;
    assign busy_o        = busy_q;
    assign irq_o         = irq_q;
    assign cause_o       = cause_q;
    assign reset_cnt_o   = reset_cnt_q;

endmodule

// File: tb/tb_guard_recovery_ctrl.sv
// Self-checking bench for guard_recovery_ctrl: directed scenarios followed by
// random traffic, all checked every cycle against a sequence-timeline model.
module tb_guard_recovery_ctrl;

    localparam int DRAIN = 256;
    localparam int RSTC  = 16;
    localparam int RECV  = 8;
    localparam int CW    = 3;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, enable, rd_req, wr_req, irq_ack;
    logic [5:0]    rd_out, wr_out;
    logic          isolate, slv_rst, reset_clear, guard_en, busy, irq;
    logic [2:0]    cause;
    logic [CW-1:0] reset_cnt;

    guard_recovery_ctrl #(
        .DrainCycles   (DRAIN),
        .RstCycles     (RSTC),
        .RecoverCycles (RECV),
        .OutCntWidth   (6),
        .RstCntWidth   (CW)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .enable_i         (enable),
        .rd_reset_req_i   (rd_req),
        .wr_reset_req_i   (wr_req),
        .rd_outstanding_i (rd_out),
        .wr_outstanding_i (wr_out),
        .irq_ack_i        (irq_ack),
        .isolate_o        (isolate),
        .slv_rst_o        (slv_rst),
        .reset_clear_o    (reset_clear),
        .guard_en_o       (guard_en),
        .busy_o           (busy),
        .irq_o            (irq),
        .cause_o          (cause),
        .reset_cnt_o      (reset_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: a sequence is a timeline counted from its start edge. e is the
    // 1-based cycle index within it; dlen is the DRAIN length once known.
    bit       m_busy;
    int       m_e, m_dlen, m_cnt;
    logic [2:0] m_cause;
    bit       m_irq;

    int iso_n, rst_n, clr_n;

    function automatic bit in_clear_phase();
        return m_busy && m_dlen != 0 && m_e > m_dlen + RSTC + RECV;
    endfunction

    task automatic model_step();
        bit zero;
        zero = (rd_out == 0) && (wr_out == 0);
        if (rst) begin
            m_busy = 0; m_e = 0; m_dlen = 0; m_cnt = 0; m_cause = 3'b000; m_irq = 0;
        end else if (!m_busy) begin
            if (enable && (rd_req || wr_req)) begin
                m_busy  = 1; m_e = 1; m_dlen = 0;
                m_cause = {1'b0, wr_req, rd_req};
                m_irq   = 1;
            end else if (irq_ack) begin
                m_irq = 0;
            end
        end else begin
            if (irq_ack) m_irq = 0;
            if (m_dlen == 0) begin
                if (zero || m_e == DRAIN) begin
                    m_dlen = m_e;
                    if (!zero) m_cause[2] = 1'b1;
                    m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
                end
                m_e++;
            end else if (m_e <= m_dlen + RSTC + RECV) begin
                m_e++;
            end else if (!rd_req && !wr_req) begin
                m_busy = 0;
            end else begin
                m_e++;
            end
        end
    endtask

    task automatic compare_all();
        bit drn, rs, rc, cl;
        drn = m_busy && m_dlen == 0;
        rs  = m_busy && m_dlen != 0 && m_e <= m_dlen + RSTC;
        rc  = m_busy && m_dlen != 0 && m_e > m_dlen + RSTC && m_e <= m_dlen + RSTC + RECV;
        cl  = in_clear_phase();
        check_eq("isolate", 32'(isolate), 32'(drn || rs || rc));
        check_eq("slv_rst", 32'(slv_rst), 32'(rs));
        check_eq("reset_clear", 32'(reset_clear), 32'(cl));
        check_eq("guard_en", 32'(guard_en), 32'(!m_busy));
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("irq", 32'(irq), 32'(m_irq));
        check_eq("cause", 32'(cause), 32'(m_cause));
        check_eq("reset_cnt", 32'(reset_cnt), 32'(m_cnt));
        if (isolate === 1'b1) iso_n++;
        if (slv_rst === 1'b1) rst_n++;
        if (reset_clear === 1'b1) clr_n++;
    endtask

    task automatic step(input logic en, input logic rr, input logic wr, input int ro,
                        input int wo, input logic ack, input logic r);
        enable = en; rd_req = rr; wr_req = wr;
        rd_out = 6'(ro); wr_out = 6'(wo); irq_ack = ack; rst = r;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int ro_v, wo_v;
        bit rr_v, wr_v, stuck;
        m_busy = 0; m_e = 0; m_dlen = 0; m_cnt = 0; m_cause = 3'b000; m_irq = 0;

        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // Read request with nothing outstanding.
        iso_n = 0; rst_n = 0; clr_n = 0;
        step(1, 1, 0, 0, 0, 0, 0);
        idle(34);
        check_eq("s1_iso_len", 32'(iso_n), 32'(1 + RSTC + RECV));
        check_eq("s1_rst_len", 32'(rst_n), 32'(RSTC));
        check_eq("s1_cause", 32'(cause), 32'(3'b001));
        check_eq("s1_cnt", 32'(reset_cnt), 32'd1);

        // Write request, traffic drains after 40 cycles.
        step(1, 0, 1, 0, 3, 0, 0);
        for (int i = 0; i < 40; i++) step(1, 0, 1, 0, 3, 0, 0);
        for (int i = 0; i < 30; i++) step(1, 0, 0, 0, 0, 0, 0);
        check_eq("s2_cause", 32'(cause), 32'(3'b010));

        // Both requests, traffic stuck: drain timeout.
        iso_n = 0;
        step(1, 1, 1, 5, 5, 0, 0);
        for (int i = 0; i < DRAIN + 40; i++) step(1, 0, 0, 5, 5, 0, 0);
        check_eq("s3_iso_len", 32'(iso_n), 32'(DRAIN + RSTC + RECV));
        check_eq("s3_cause", 32'(cause), 32'(3'b111));

        // Request held into CLEAR for three extra cycles.
        clr_n = 0;
        for (int i = 0; i < 1 + 1 + RSTC + RECV + 3; i++) step(1, 1, 0, 0, 0, 0, 0);
        idle(5);
        check_eq("s4_clear_len", 32'(clr_n), 32'd4);
        check_eq("s4_idle", 32'(busy), 32'd0);

        // Ack coincides with a new trigger: set wins.
        step(1, 1, 0, 0, 0, 1, 0);
        check_eq("s5_irq_set_wins", 32'(irq), 32'd1);
        idle(30);

        // Reset mid-RESET.
        step(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        check_eq("s6_slv_rst", 32'(slv_rst), 32'd0);
        check_eq("s6_cnt", 32'(reset_cnt), 32'd0);

        // Enable low blocks a start.
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 0, 0, 0);
        check_eq("s7_no_start", 32'(busy), 32'd0);

        // Saturate the entry counter.
        for (int k = 0; k < CMAX + 2; k++) begin
            step(1, 1, 0, 0, 0, 0, 0);
            idle(30);
        end
        check_eq("s8_cnt_sat", 32'(reset_cnt), 32'(CMAX));

        // Random traffic.
        ro_v = 0; wo_v = 0; rr_v = 0; wr_v = 0; stuck = 0;
        for (int c = 0; c < 6000; c++) begin
            if (!m_busy) begin
                if ($urandom_range(0, 15) == 0) rr_v = 1;
                if ($urandom_range(0, 15) == 0) wr_v = 1;
                if (rr_v || wr_v) stuck = ($urandom_range(0, 5) == 0);
            end else if (in_clear_phase() || $urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 2) == 0) rr_v = 0;
                if ($urandom_range(0, 2) == 0) wr_v = 0;
            end
            if (!stuck && $urandom_range(0, 5) == 0) begin
                ro_v = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 63));
                wo_v = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 63));
            end else if (stuck) begin
                ro_v = 7;
                if (m_busy && m_dlen != 0) stuck = 0;
            end
            step($urandom_range(0, 9) != 0, rr_v, wr_v, ro_v, wo_v,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 999) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
